// File: rtl/pmod_capture.sv
// -----------------------------------------------------------------------------
// pmod_capture
//   8-bit parallel sampler for the pmod header. It samples pmod_in once every
//   SAMPLE_PERIOD ref_clk cycles, waits for a level-crossing trigger and keeps
//   a DEPTH-sample window (PRE_TRIG samples before the trigger sample, the
//   trigger sample itself, and the rest after it) in a ring buffer. The window
//   is then played back oldest-first through a one-cycle read handshake.
//
// Ports
//   ref_clk      system clock (12 MHz)
//   rst          asynchronous active-low reset
//   pmod_in      asynchronous 8-bit sample bus (synchronised internally)
//   arm          starts a capture when idle or holding a window
//   trig_level   unsigned trigger threshold
//   trig_rising  1 = rising crossing, 0 = falling crossing
//   busy         capture in progress (pre-fill, waiting for trigger, post-fill)
//   done         complete window held, ready for readout
//   rd_en        one-cycle read request, honoured only while done
//   rd_data      sample read out
//   rd_valid     one-cycle qualifier for rd_data
//   rd_last      marks the final sample of the window
// -----------------------------------------------------------------------------
module pmod_capture #(
   parameter int SAMPLE_PERIOD = 12,
   parameter int DEPTH         = 64,
   parameter int PRE_TRIG      = 16
) (
   input  logic       ref_clk,
   input  logic       rst,
   input  logic [7:0] pmod_in,
   input  logic       arm,
   input  logic [7:0] trig_level,
   input  logic       trig_rising,
   output logic       busy,
   output logic       done,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       rd_last
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(SAMPLE_PERIOD);

   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
   localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
   localparam logic [AW-1:0] POST_LEN  = AW'(DEPTH - PRE_TRIG - 1);
   localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT_TRIG,
      S_POST,
      S_DONE
   } state_t;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [7:0]    sync1;
   logic [7:0]    sync2;
   logic [7:0]    prev_sample;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] pre_cnt;
   logic [AW-1:0] post_cnt;
   logic [AW-1:0] rd_cnt;
   logic          wr_en;
   logic          trig_hit;
   logic [7:0]    mem [DEPTH];

   // Two-flop synchroniser; sync2 is the sample value.
   // NOTE: non-blocking assignments make sync2 take the pre-edge sync1, so the
   // chain really is two stages deep; blocking would collapse it to one.
   always_ff @(posedge ref_clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pmod_in;
         sync2 <= sync1;
      end
   end

   // Free-running sample-rate divider, independent of the capture state.
   always_ff @(posedge ref_clk or negedge rst) begin
      if (!rst)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   assign tick  = (tick_cnt == TICK_LAST);
   assign wr_en = tick && (state == S_PRE || state == S_WAIT_TRIG || state == S_POST);

   // Crossing detect between the last written sample and the incoming one.
   always_comb begin
      // NOTE: default first so no path leaves trig_hit unassigned (no latch).
      trig_hit = 1'b0;
      if (trig_rising)
         trig_hit = (prev_sample < trig_level) && (sync2 >= trig_level);
      else
         trig_hit = (prev_sample > trig_level) && (sync2 <= trig_level);
   end

   // NOTE: the sample buffer is deliberately left without a reset so it maps
   // onto block RAM; its contents are only read after a full window is written.
   always_ff @(posedge ref_clk) begin
      if (wr_en)
         mem[wptr] <= sync2;
   end

   always_ff @(posedge ref_clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         rd_last     <= 1'b0;
         wptr        <= '0;
         rptr        <= '0;
         trig_addr   <= '0;
         pre_cnt     <= '0;
         post_cnt    <= '0;
         rd_cnt      <= '0;
         prev_sample <= '0;
      end else begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;

         if (wr_en) begin
            wptr        <= wptr + 1'b1;
            prev_sample <= sync2;
         end

         case (state)
            S_IDLE: begin
               if (arm) begin
                  state   <= S_PRE;
                  busy    <= 1'b1;
                  wptr    <= '0;
                  pre_cnt <= '0;
               end
            end

            S_PRE: begin
               if (tick) begin
                  pre_cnt <= pre_cnt + 1'b1;
                  if (pre_cnt == PRE_LAST)
                     state <= S_WAIT_TRIG;
               end
            end

            S_WAIT_TRIG: begin
               if (tick && trig_hit) begin
                  trig_addr <= wptr;
                  post_cnt  <= POST_LEN;
                  if (POST_LEN == '0) begin
                     // Window ends on the trigger sample itself.
                     state  <= S_DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     rptr   <= wptr - PRE_OFS;
                     rd_cnt <= '0;
                  end else begin
                     state <= S_POST;
                  end
               end
            end

            S_POST: begin
               if (tick) begin
                  post_cnt <= post_cnt - 1'b1;
                  if (post_cnt == AW'(1)) begin
                     state  <= S_DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     rptr   <= trig_addr - PRE_OFS;
                     rd_cnt <= '0;
                  end
               end
            end

            S_DONE: begin
               // A new arm abandons the readout and outranks a read request.
               if (arm) begin
                  state   <= S_PRE;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  wptr    <= '0;
                  pre_cnt <= '0;
               end else if (rd_en) begin
                  rd_data  <= mem[rptr];
                  rd_valid <= 1'b1;
                  rptr     <= rptr + 1'b1;
                  rd_cnt   <= rd_cnt + 1'b1;
                  if (rd_cnt == RD_LAST) begin
                     rd_last <= 1'b1;
                     state   <= S_IDLE;
                     done    <= 1'b0;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmod_capture.sv
// -----------------------------------------------------------------------------
// tb_pmod_capture
//   Directed bench for pmod_capture with default parameters. Each capture is
//   driven from a per-test stimulus list, one value per sample tick; values
//   that fall inside the expected window are queued as they are driven and
//   popped against rd_data during readout.
// -----------------------------------------------------------------------------
module tb_pmod_capture;

   localparam int SP    = 12;
   localparam int DEPTH = 64;
   localparam int PRE   = 16;
   localparam int POST  = DEPTH - PRE - 1;

   logic       ref_clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] pmod_in = '0;
   logic       arm = 1'b0;
   logic [7:0] trig_level = '0;
   logic       trig_rising = 1'b1;
   logic       busy;
   logic       done;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_last;

   int         n_cmp = 0;
   int         n_err = 0;
   int         phase;
   logic [7:0] stim[$];
   logic [7:0] exp_q[$];

   pmod_capture dut (
      .ref_clk     (ref_clk),
      .rst         (rst),
      .pmod_in     (pmod_in),
      .arm         (arm),
      .trig_level  (trig_level),
      .trig_rising (trig_rising),
      .busy        (busy),
      .done        (done),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_last     (rd_last)
   );

   always #5 ref_clk = ~ref_clk;

   // Sample-tick phase: phase == SP-1 before an edge means that edge writes.
   always @(posedge ref_clk or negedge rst) begin
      if (!rst)
         phase <= 0;
      else
         phase <= (phase == SP - 1) ? 0 : phase + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Return #1 after the next edge on which the DUT writes a sample.
   task automatic wait_tick();
      do @(posedge ref_clk); while (phase != SP - 1);
      #1;
   endtask

   task automatic drive(input int j, input bit full, input int trig_idx);
      pmod_in = stim[j];
      if (full && j >= trig_idx - PRE && j <= trig_idx + POST)
         exp_q.push_back(stim[j]);
   endtask

   // Arm, then feed stim[] one value per tick. stop_at < 0 runs to the end of
   // the window; otherwise the capture is left running after index stop_at.
   task automatic run_capture(input int trig_idx, input int stop_at, input string tag);
      int  last;
      bit  full;
      full = (stop_at < 0);
      last = full ? trig_idx + POST : stop_at;
      wait_tick();
      drive(0, full, trig_idx);
      arm = 1'b1;
      @(posedge ref_clk);
      #1;
      arm = 1'b0;
      check({tag, "_busy_after_arm"}, busy, 1);
      for (int i = 0; i <= last; i++) begin
         wait_tick();
         if (i < trig_idx + POST) begin
            check({tag, "_busy_cap"}, busy, 1);
            check({tag, "_done_cap"}, done, 0);
         end else begin
            check({tag, "_busy_end"}, busy, 0);
            check({tag, "_done_end"}, done, 1);
         end
         if (i < last)
            drive(i + 1, full, trig_idx);
      end
   endtask

   // Back-to-back reads of the whole window.
   task automatic read_window(input string tag);
      logic [7:0] exp;
      rd_en = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         @(posedge ref_clk);
         #1;
         if (k == DEPTH - 1)
            rd_en = 1'b0;
         exp = exp_q.pop_front();
         check({tag, "_rd_valid"}, rd_valid, 1);
         check({tag, "_rd_data"}, rd_data, exp);
         check({tag, "_rd_last"}, rd_last, (k == DEPTH - 1));
      end
      check({tag, "_done_after_rd"}, done, 0);
      check({tag, "_busy_after_rd"}, busy, 0);
      @(posedge ref_clk);
      #1;
      check({tag, "_valid_drop"}, rd_valid, 0);
      check({tag, "_last_drop"}, rd_last, 0);
      rd_en = 1'b1;
      @(posedge ref_clk);
      #1;
      rd_en = 1'b0;
      check({tag, "_idle_rd_ignored"}, rd_valid, 0);
   endtask

   initial begin
      // 1: inputs toggle while reset is held, then a clean IDLE.
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         arm         = c[0];
         rd_en       = ~c[0];
         pmod_in     = 8'hA5 ^ 8'(c);
         trig_level  = 8'h3C + 8'(c);
         trig_rising = c[1];
         @(posedge ref_clk);
         #1;
      end
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_rd_data", rd_data, 0);
      arm   = 1'b0;
      rd_en = 1'b0;
      rst   = 1'b1;
      repeat (3) @(posedge ref_clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      rd_en = 1'b1;
      @(posedge ref_clk);
      #1;
      rd_en = 1'b0;
      check("idle_rd_valid", rd_valid, 0);
      check("idle_rd_data", rd_data, 0);

      // 2: rising ramp through 100.
      trig_level  = 8'd100;
      trig_rising = 1'b1;
      stim.delete();
      for (int i = 0; i <= 100 + POST; i++) stim.push_back(8'(i));
      run_capture(100, -1, "t2");
      read_window("t2");

      // 3: falling ramp from 255 through 50.
      trig_level  = 8'd50;
      trig_rising = 1'b0;
      stim.delete();
      for (int i = 0; i <= 205 + POST; i++) stim.push_back(8'(255 - i));
      run_capture(205, -1, "t3");
      read_window("t3");

      // 4: flat above the level for 1000 ticks, then 0 -> 150 crossing.
      trig_level  = 8'd100;
      trig_rising = 1'b1;
      stim.delete();
      for (int i = 0; i < 1000; i++) stim.push_back(8'd200);
      stim.push_back(8'd0);
      stim.push_back(8'd150);
      for (int j = 0; j < POST; j++) stim.push_back(8'(160 + j));
      run_capture(1001, -1, "t4");
      read_window("t4");

      // 5: crossing inside the pre-fill must not trigger; 50 -> 120 later does.
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(8'd99);
      for (int i = 8; i <= 20; i++) stim.push_back(8'd100);
      stim.push_back(8'd50);
      stim.push_back(8'd120);
      for (int j = 0; j < POST; j++) stim.push_back(8'(121 + j));
      run_capture(22, -1, "t5");
      read_window("t5");

      // arm outranks rd_en while a window is held.
      run_capture(22, -1, "t5b");
      arm   = 1'b1;
      rd_en = 1'b1;
      @(posedge ref_clk);
      #1;
      arm   = 1'b0;
      rd_en = 1'b0;
      check("prio_rd_valid", rd_valid, 0);
      check("prio_busy", busy, 1);
      check("prio_done", done, 0);
      exp_q.delete();
      rst = 1'b0;
      #1;
      check("prio_rst_busy", busy, 0);
      repeat (2) @(posedge ref_clk);
      #1;
      rst = 1'b1;

      // 6: reset in the middle of the post-fill.
      stim.delete();
      for (int i = 0; i <= 110; i++) stim.push_back(8'(i));
      run_capture(100, 110, "t6a");
      rst = 1'b0;
      #1;
      check("t6_async_busy", busy, 0);
      check("t6_async_done", done, 0);
      repeat (2) @(posedge ref_clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 80; i++) begin
         pmod_in = 8'(i * 3);
         wait_tick();
         check("t6_idle_done", done, 0);
         check("t6_idle_busy", busy, 0);
      end
      trig_level = 8'd90;
      stim.delete();
      for (int i = 0; i <= 60 + POST; i++) stim.push_back(8'(30 + i));
      run_capture(60, -1, "t6b");
      read_window("t6b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pmod_capture.md
Name: pmod_capture

Overview:
- 8-bit parallel sampler for the pmod header. It is the input-side counterpart of the AWG, which drives 8-bit codes out.
- Samples an external 8-bit ADC/logic bus at a divided rate and waits for a level-crossing trigger.
- Stores a fixed window of pre- and post-trigger samples in an on-chip ring buffer.
- Plays the window back oldest-first over a simple read handshake for the bench or a UART/LED consumer.

Parameters:
SAMPLE_PERIOD, 12, ref_clk cycles per sample tick (12 -> 1 MHz at 12 MHz ref_clk); must be >= 2
DEPTH, 64, capture window length in samples; power of two, >= 4
PRE_TRIG, 16, samples kept before the trigger sample; 1 <= PRE_TRIG <= DEPTH-1

Ports:
ref_clk  input  1  12 MHz system clock
rst  input  1  asynchronous, active-low reset (0 = reset)
pmod_in  input  8  asynchronous sample bus from the pmod header
arm  input  1  level; sampled each ref_clk; starts a capture when in IDLE or DONE
trig_level  input  8  unsigned trigger threshold
trig_rising  input  1  1 = rising-crossing trigger, 0 = falling-crossing trigger
busy  output  1  high while capture is in progress (PRE, WAIT_TRIG, POST)
done  output  1  high while a complete window is held (DONE)
rd_en  input  1  one-cycle read request, honoured only in DONE
rd_data  output  8  sample read out
rd_valid  output  1  rd_data qualifier, one-cycle pulse
rd_last  output  1  high with rd_valid on the final (DEPTH-th) sample

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, rd_valid=0, rd_last=0, rd_data=0; tick counter=0; synchronizer flops=0. Buffer contents are undefined. Reset mid-capture or mid-readout abandons the capture without a done pulse.
- Input path: two-flop synchronizer on pmod_in. The sample is the synchronizer output on a tick cycle.
- Tick: a free-running counter counts 0..SAMPLE_PERIOD-1. tick=1 for one cycle when the counter equals SAMPLE_PERIOD-1, then the counter wraps to 0. The counter is independent of state.
- Write pointer: log2(DEPTH) bits, wraps modulo DEPTH. It is cleared on arm acceptance. In PRE/WAIT_TRIG/POST every tick writes the sample at wptr, then wptr increments.
- IDLE: arm=1 -> PRE, busy=1 on the next cycle.
- PRE:
  - Counts written samples.
  - After PRE_TRIG samples -> WAIT_TRIG.
  - Triggers are not evaluated in PRE, but prev_sample is updated on every write.
- WAIT_TRIG: on each tick, compare the new sample s with prev_sample p.
  - Rising trigger: p < trig_level and s >= trig_level.
  - Falling trigger: p > trig_level and s <= trig_level.
  - Comparisons are unsigned 8-bit.
  - On trigger: s is written, trig_addr = its address, post_cnt = DEPTH-PRE_TRIG-1.
  - If post_cnt=0 -> DONE; else -> POST.
  - Without a trigger, state stays WAIT_TRIG indefinitely and the buffer keeps overwriting.
- POST: each tick writes and decrements post_cnt. The write that takes it to 0 -> DONE.
- DONE:
  - busy=0, done=1.
  - Read pointer initialized to trig_addr - PRE_TRIG (mod DEPTH), i.e. the oldest sample in the window.
  - rd_en=1 at cycle N -> rd_data/rd_valid=1 at N+1, then the pointer increments. Back-to-back rd_en every cycle is legal.
  - The DEPTH-th read asserts rd_last with rd_valid; state -> IDLE, done=0 on the same edge.
  - rd_valid and rd_last are 0 in all other cycles.
- Priority in DONE: arm=1 wins over rd_en. The readout is abandoned, wptr is cleared, and state -> PRE; no rd_valid is issued that cycle.
- Ignored inputs: arm is ignored in PRE/WAIT_TRIG/POST; rd_en is ignored outside DONE.
- Trigger parameters: trig_level and trig_rising are read live each tick. Changing them mid-capture is legal and affects subsequent comparisons only.

Test Plan:
1. Hold rst=0, toggle all inputs, release -> busy=done=rd_valid=rd_last=0, rd_data=0, state IDLE. Pulsing rd_en gives no rd_valid.
2. Defaults; pmod_in ramps +1 per tick starting at 0 on the first post-arm tick; trig_level=100, trig_rising=1; arm -> trigger on sample 100. DEPTH rd_en pulses return 84,85,...,147, with rd_last only on 147; done drops after 147.
3. pmod_in ramps down from 255 per tick; trig_level=50, trig_rising=0 -> trigger at 50. Readout is 66 down to 3, 64 values, with rd_last on 3.
4. pmod_in constant 200, trig_level=100, rising; arm -> busy stays 1 and done stays 0 for 1000 ticks. Then step pmod_in to 0 then 150 -> trigger fires, and done asserts DEPTH-PRE_TRIG-1 ticks after the 150 sample.
5. A crossing 99->100 placed within the first 16 samples (PRE), followed by a flat 100 -> no trigger. A later 50->120 crossing triggers, and the readout starts 16 samples before the 120.
6. Assert rst=0 mid-POST -> busy=0 immediately (async). After release, done never asserts without a new arm; a subsequent full capture reads out correctly.
